alu_driver: RTL and testbench

Sequencing initiator for the 8-bit combinational ALU. Accepts one operation request at a time over a valid/ready handshake and drives the ALU operand/opcode inputs from registers. Waits a per-opcode number of clock cycles covering the ALU's propagation delay, then captures S, G and CarryOut. Returns the result over a valid/ready response handshake. Sits between the datapath controller and the ALU instance.

---
 rtl/alu_driver.sv | 149 ++++++++++++++
 tb/tb_alu_driver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - sequencing initiator for the 8-bit combinational ALU
//
// Accepts one request at a time and drives the ALU from registers. It waits a
// per-opcode settle time, then captures the ALU result and returns it over a
// response handshake.
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   req_valid/req_ready        request handshake; req_op/req_a/req_b carry the payload
//   A, B, F                    registered operands/opcode driven to the ALU
//   S, G, CarryOut             ALU result, A>B flag, carry/borrow
//   rsp_valid/rsp_ready        response handshake
//   rsp_s/rsp_carry/rsp_gt     captured result and flags
//   rsp_op                     opcode of the response
//   op_count                   completed responses, wraps modulo 2^16
module alu_driver #(
  parameter int unsigned WAIT_ADD   = 7,
  parameter int unsigned WAIT_MAX   = 8,
  parameter int unsigned WAIT_CLR   = 2,
  parameter int unsigned WAIT_LOGIC = 6,
  parameter int unsigned WAIT_DBL   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [2:0]  F,
  input  logic [7:0]  S,
  input  logic        G,
  input  logic        CarryOut,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_s,
  output logic        rsp_carry,
  output logic        rsp_gt,
  output logic [2:0]  rsp_op,
  output logic [15:0] op_count
);

  localparam int unsigned W01  = (WAIT_ADD > WAIT_MAX) ? WAIT_ADD : WAIT_MAX;
  localparam int unsigned W23  = (WAIT_CLR > WAIT_LOGIC) ? WAIT_CLR : WAIT_LOGIC;
  localparam int unsigned W03  = (W01 > W23) ? W01 : W23;
  localparam int unsigned WTOP = (W03 > WAIT_DBL) ? W03 : WAIT_DBL;
  localparam int unsigned CW   = $clog2(WTOP + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    a_q;
  logic [7:0]    b_q;
  logic [2:0]    f_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_s_q;
  logic          rsp_carry_q;
  logic          rsp_gt_q;
  logic [2:0]    rsp_op_q;
  logic [15:0]   op_count_q;
  logic [7:0]    rsp_s_d;

  function automatic logic [CW-1:0] wait_for(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b011: wait_for = CW'(WAIT_ADD);
      3'b010:                 wait_for = CW'(WAIT_MAX);
      3'b100:                 wait_for = CW'(WAIT_CLR);
      3'b101, 3'b110:         wait_for = CW'(WAIT_LOGIC);
      default:                wait_for = CW'(WAIT_DBL);
    endcase
  endfunction

  // The ALU does not update S for max when A >= B, so the answer is A itself.
  always_comb begin
    rsp_s_d = S;
    if (f_q == 3'b010 && a_q >= b_q) begin
      rsp_s_d = a_q;
    end
  end

  // req_ready is held low while rst_n is low.
  assign req_ready = rst_n && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_s_q     <= '0;
      rsp_carry_q <= 1'b0;
      rsp_gt_q    <= 1'b0;
      rsp_op_q    <= '0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            f_q     <= req_op;
            cnt_q   <= wait_for(req_op);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          // cnt == 1 marks the last settle cycle, so the ALU outputs are valid now.
          if (cnt_q == CW'(1)) begin
            rsp_s_q     <= rsp_s_d;
            rsp_carry_q <= CarryOut;
            rsp_gt_q    <= G;
            rsp_op_q    <= f_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 16'd1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign F         = f_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_gt    = rsp_gt_q;
  assign rsp_op    = rsp_op_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - scoreboard bench for alu_driver with a behavioural ALU
module tb_alu_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  F;
  logic [7:0]  S;
  logic        G;
  logic        CarryOut;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_s;
  logic        rsp_carry;
  logic        rsp_gt;
  logic [2:0]  rsp_op;
  logic [15:0] op_count;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       g;
    logic [2:0] op;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] cnt_model = 16'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_driver dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .A(A), .B(B), .F(F),
    .S(S), .G(G), .CarryOut(CarryOut),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_carry(rsp_carry), .rsp_gt(rsp_gt),
    .rsp_op(rsp_op), .op_count(op_count)
  );

  // Behavioural ALU; for max with A >= B it deliberately leaves junk on S.
  function automatic logic [8:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [8:0] t;
    case (op)
      3'b000:  t = {1'b0, a} + {1'b0, b};
      3'b001:  t = {1'b0, a} - {1'b0, b};
      3'b010:  t = (a < b) ? {1'b0, b} : 9'h05A;
      3'b011:  begin t = {1'b0, a} + {1'b0, b}; t = {t[8], t[8:1]}; end
      3'b100:  t = 9'h000;
      3'b101:  t = {1'b0, a | b};
      3'b110:  t = {1'b0, a & b};
      default: t = {1'b0, b} + {1'b0, b};
    endcase
    return t;
  endfunction

  logic [8:0] alu_out;
  always_comb begin
    alu_out  = alu_model(F, A, B);
    S        = alu_out[7:0];
    CarryOut = alu_out[8];
    G        = (A > B);
  end

  function automatic exp_t expect_of(input logic [2:0] op, input logic [7:0] a,
                                     input logic [7:0] b);
    exp_t       e;
    logic [8:0] t;
    t    = alu_model(op, a, b);
    e.s  = (op == 3'b010) ? ((a >= b) ? a : b) : t[7:0];
    e.c  = t[8];
    e.g  = (a > b);
    e.op = op;
    return e;
  endfunction

  function automatic int wait_of(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b011: return 7;
      3'b010:                 return 8;
      3'b100:                 return 2;
      3'b101, 3'b110:         return 6;
      default:                return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Present a request and wait (bounded) for the accept edge; returns at accept+1.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int guard;
    guard     = 0;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_timeout", 32'(guard < 50), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back(expect_of(op, a, b));
    check("operands_loaded", 32'({F, A, B}), 32'({op, a, b}));
    check("req_ready_busy", 32'(req_ready), 32'd0);
  endtask

  task automatic wait_rsp(input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    e = sb.pop_front();
    check("rsp_s", 32'(rsp_s), 32'(e.s));
    check("rsp_carry", 32'(rsp_carry), 32'(e.c));
    check("rsp_gt", 32'(rsp_gt), 32'(e.g));
    check("rsp_op", 32'(rsp_op), 32'(e.op));
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cnt_model = cnt_model + 16'd1;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("op_count", 32'(op_count), 32'(cnt_model));
    check("req_ready_idle", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] hold_s;
    logic [4:0] hold_f;
    logic [2:0] ops[5];
    int         hs;
    logic       seen;
    ops = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b110};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_abf", 32'({A, B, F}), 32'd0);
    check("reset_rsp", 32'({rsp_valid, rsp_s, rsp_carry, rsp_gt, rsp_op}), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_reset_req_ready", 32'(req_ready), 32'd1);

    // Reset during WAIT cycle 3 of an add aborts it.
    send(3'b000, 8'd1, 8'd2);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    void'(sb.pop_back());
    check("abort_abf", 32'({A, B, F}), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("abort_release_ready", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    check("abort_op_count", 32'(op_count), 32'(cnt_model));

    // Directed cases.
    send(3'b000, 8'd200, 8'd100); wait_rsp(7); ack();
    send(3'b010, 8'd5, 8'd9);     wait_rsp(8); ack();
    send(3'b010, 8'd9, 8'd5);     wait_rsp(8); ack();
    send(3'b111, 8'd0, 8'h80);    wait_rsp(1); ack();

    // Remaining opcodes with random operands.
    foreach (ops[i]) begin
      send(ops[i], 8'($urandom), 8'($urandom));
      wait_rsp(wait_of(ops[i]));
      ack();
    end

    // Backpressure with a pending request.
    send(3'b000, 8'd17, 8'd250);
    wait_rsp(7);
    req_op = 3'b101; req_a = 8'h3C; req_b = 8'hC1; req_valid = 1'b1;
    hold_s = rsp_s;
    hold_f = {rsp_carry, rsp_gt, rsp_op};
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_stable", 32'({rsp_s, rsp_carry, rsp_gt, rsp_op}), 32'({hold_s, hold_f}));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_op_count", 32'(op_count), 32'(cnt_model));
    end
    ack();
    hs = cyc;
    send(3'b101, 8'h3C, 8'hC1);
    check("bp_next_accept", 32'(cyc), 32'(hs + 1));
    wait_rsp(6);
    ack();

    // Counter wrap.
    @(negedge clk);
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    cnt_model = 16'hFFFF;
    @(posedge clk); #1;
    send(3'b100, 8'h12, 8'h34);
    wait_rsp(2);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
